uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Oversampling UART receiver. It is the far-end partner of the team's uart_tx serializer, which sends 8N1 frames: start bit, LSB first, stop bit.
- Replaces divided-clock sampling with a 16x tick, a 2-flop input synchronizer, mid-bit sampling, false-start rejection and framing-error detection.
- Whole block runs on clk; no derived clocks.

Parameters:
clk_freq, 1_600_000, system clock frequency in Hz
baud_rate, 10_000, line bit rate in baud
oversample, 16, ticks per bit period; must be an even number >= 4
(tick divisor DIV = clk_freq/(baud_rate*oversample), integer-truncated, must be >= 1; default DIV=10, bit period 160 clk)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-low reset (0 = reset)
rx  input  1  asynchronous serial line, idle high
dout  output  8  last correctly framed byte; held until the next good frame
donerx  output  1  one-clk pulse: dout updated with a new byte
ferr  output  1  one-clk pulse: stop bit sampled low, byte discarded
perr  output  1  one-clk pulse: parity mismatch (PARITY_EN only, else tied 0)
busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE; dout=8'h00; donerx=ferr=perr=busy=0; both synchronizer flops=1; tick and bit counters=0.
  - Reset mid-frame aborts the frame with no pulse.
- Tick generator: counter 0..DIV-1; tick is high one clk when counter==DIV-1. It free-runs and is not restarted per frame.
- Sample counter (0..oversample-1) advances on tick only.
- Input path: rx_s = 2-flop synchronized rx. All decisions use rx_s.
- States:
  - IDLE: busy=0. On rx_s==0, clear sample counter and go to START.
  - START: after oversample/2 ticks (mid start bit):
    - rx_s==1 -> false start, back to IDLE, no pulse.
    - else clear sample counter, bit index=0, go to DATA.
  - DATA: every oversample ticks, shift rx_s into shreg[7] with right shift, so the first bit lands in shreg[0] after 8 shifts (LSB first). After the 8th sample go to STOP, or to PARITY when enabled.
  - STOP: after oversample ticks, sample rx_s:
    - 1 -> dout<=shreg and donerx=1 for the next clk. Go to IDLE.
    - 0 -> ferr=1 for one clk; dout unchanged. Go to BRK.
  - BRK: wait until rx_s==1, then go to IDLE. This prevents re-triggering on a held-low break line.
- Latency: donerx rises 1 clk after the tick that samples mid-stop-bit, about 9.5 bit periods + 3 clk after the falling start edge at the rx pin.
- donerx, ferr and perr are mutually exclusive and never assert in consecutive frames without a new start bit.
- A new start edge arriving in the same clk that IDLE is re-entered is accepted on the next clk; back-to-back frames with no idle gap are supported.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - PARITY state after DATA samples one extra bit.
  - Even parity expected: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: perr pulses 1 clk, dout unchanged, donerx suppressed. STOP is still checked; ferr has priority over perr.
- When undefined:
  - No PARITY state; perr driven constant 0; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP, BRK};
  - localparam function calc_div(clk_freq, baud_rate, oversample);
  - constant DATA_BITS = 8.
- Sub-module uart_baud_tick (params clk_freq, baud_rate, oversample; ports clk, rst, tick), reusable by a future oversampled transmitter.

Test Plan:
- Reset: hold rst=0 for 5 clk with rx toggling -> dout=8'h00, all pulses 0, busy=0. Release with rx=1 -> stays IDLE.
- Good frame: send 8'hA5 at 160 clk/bit -> exactly one donerx pulse, dout=8'hA5, ferr=0. Then back-to-back frames 8'h00 and 8'hFF with no idle gap -> two donerx pulses, dout ends at 8'hFF.
- False start: rx low for 40 clk then high -> no pulse, busy falls within 90 clk, next frame 8'h3C is received correctly.
- Framing error: send 8'h55 with stop bit 0 and hold rx low for 2000 clk -> one ferr pulse, dout keeps its prior value. No further pulse until rx returns high and a new frame 8'h81 gives donerx with dout=8'h81.
- Mid-frame reset: assert rst=0 during bit 4 of 8'hC3 -> no pulse, state IDLE. Next clean frame 8'h5A -> dout=8'h5A.
- Parity (UART_RX_PARITY_EN): 8'h07 with parity 1 -> donerx, dout=8'h07. Same byte with parity 0 -> perr pulse, no donerx.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART blocks.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} rx_state_t;

  // Clock cycles per oversample tick, integer-truncated.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clk pulse every calc_div() clocks, never restarted per frame.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1_600_000,
  parameter int baud_rate  = 10_000,
  parameter int oversample = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(clk_freq, baud_rate, oversample);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled 8N1 UART receiver with mid-bit sampling, false-start and framing checks.
// Even parity bit between data and stop is added when UART_RX_PARITY_EN is defined.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1_600_000,
  parameter int baud_rate  = 10_000,
  parameter int oversample = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       donerx,
  output logic       ferr,
  output logic       perr,
  output logic       busy
);

  localparam int SW = $clog2(oversample);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HALF_LAST = SW'(oversample / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(oversample - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_tick;
  logic                 w_rx_s;
  logic                 r_sync1, r_sync2;
  rx_state_t            r_state;
  logic [SW-1:0]        r_scnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shreg;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
`endif

  uart_baud_tick #(
    .clk_freq  (clk_freq),
    .baud_rate (baud_rate),
    .oversample(oversample)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_scnt  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      dout    <= 8'h00;
      donerx  <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      donerx <= 1'b0;
      ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_scnt  <= '0;
            busy    <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_scnt == HALF_LAST) begin
              r_scnt <= '0;
              if (w_rx_s) begin
                busy    <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_bit   <= '0;
                r_state <= DATA;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_scnt == FULL_LAST) begin
              r_scnt  <= '0;
              r_shreg <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
              r_bit   <= r_bit + 1'b1;
              if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            if (r_scnt == FULL_LAST) begin
              r_scnt  <= '0;
              r_par   <= w_rx_s;
              r_state <= STOP;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            if (r_scnt == FULL_LAST) begin
              r_scnt <= '0;
              if (w_rx_s) begin
                busy    <= 1'b0;
                r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (^{r_shreg, r_par}) begin
                  perr <= 1'b1;
                end else begin
                  dout   <= r_shreg;
                  donerx <= 1'b1;
                end
`else
                dout   <= r_shreg;
                donerx <= 1'b1;
`endif
              end else begin
                // Framing error wins over parity; stay busy until the line releases.
                ferr    <= 1'b1;
                r_state <= BRK;
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        BRK: begin
          if (w_rx_s) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed plan steps plus random frames against a frame-level model.
module tb_uart_rx_os;

  localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] dout;
  logic       donerx, ferr, perr, busy;

  uart_rx_os #(
    .clk_freq  (1_600_000),
    .baud_rate (10_000),
    .oversample(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .dout  (dout),
    .donerx(donerx),
    .ferr  (ferr),
    .perr  (perr),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed pulse activity
  int n_done = 0, n_ferr = 0, n_perr = 0, n_multi = 0;
  logic [7:0] rxq[$];

  // Reference model state: what the line frames should have produced
  int e_done = 0, e_ferr = 0, e_perr = 0;
  logic [7:0] e_dout = 8'h00;
  logic [7:0] expq[$];

  always @(negedge clk) begin
    if (donerx) begin
      n_done++;
      rxq.push_back(dout);
    end
    if (ferr) n_ferr++;
    if (perr) n_perr++;
    if (int'(donerx) + int'(ferr) + int'(perr) > 1) n_multi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  // Sends one frame; line is left at the stop-bit level. Model decides the outcome.
  task automatic send(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PEN) drive_bit(par);
    drive_bit(stop);
    if (!stop) begin
      e_ferr++;
    end else if (PEN && ((^d) ^ par)) begin
      e_perr++;
    end else begin
      e_done++;
      e_dout = d;
      expq.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " donerx count"}, n_done, e_done);
    chk({tag, " ferr count"}, n_ferr, e_ferr);
    chk({tag, " perr count"}, n_perr, e_perr);
    chk({tag, " dout"}, {24'h0, dout}, {24'h0, e_dout});
    chk({tag, " pulse overlap"}, n_multi, 0);
    while (expq.size() > 0) begin
      if (rxq.size() > 0) chk({tag, " byte"}, {24'h0, rxq.pop_front()}, {24'h0, expq.pop_front()});
      else void'(expq.pop_front());
    end
    rxq.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    int         k;

    // Reset with rx toggling
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      rx = ~rx;
    end
    chk("reset dout", {24'h0, dout}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset donerx", {31'h0, donerx}, 32'h0);
    chk("reset ferr", {31'h0, ferr}, 32'h0);
    chk("reset perr", {31'h0, perr}, 32'h0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(50);
    chk("idle after reset busy", {31'h0, busy}, 32'h0);
    check_all("idle after reset");

    // Good frame, then back-to-back frames with no gap
    send(8'hA5, 1'b1, ^8'hA5);
    idle(BIT);
    check_all("frame a5");
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    idle(BIT);
    check_all("back to back");

    // False start: short low glitch
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("false start busy high", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    k = 0;
    while (busy && k < 90) begin
      @(negedge clk);
      k++;
    end
    chk("false start busy fell", {31'h0, busy}, 32'h0);
    idle(BIT);
    check_all("false start");
    send(8'h3C, 1'b1, ^8'h3C);
    idle(BIT);
    check_all("frame 3c");

    // Framing error followed by a held-low break
    send(8'h55, 1'b0, ^8'h55);
    repeat (2000) @(negedge clk);
    chk("break busy", {31'h0, busy}, 32'h1);
    check_all("framing error");
    idle(2 * BIT);
    chk("after break busy", {31'h0, busy}, 32'h0);
    check_all("break released");
    send(8'h81, 1'b1, ^8'h81);
    idle(BIT);
    check_all("frame 81");

    // Reset in the middle of bit 4 of 8'hC3
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    chk("midframe reset busy", {31'h0, busy}, 32'h0);
    repeat (5 * BIT) @(negedge clk);
    rst = 1'b1;
    e_dout = 8'h00;
    idle(BIT);
    chk("after midframe reset busy", {31'h0, busy}, 32'h0);
    check_all("midframe reset");
    send(8'h5A, 1'b1, ^8'h5A);
    idle(BIT);
    check_all("frame 5a");

    // Random frames with random gaps (including zero gap)
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      p = (^d) ^ (PEN && ($urandom_range(0, 3) == 0));
      send(d, 1'b1, p);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 400)));
    end
    idle(BIT);
    check_all("random");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1);
    idle(BIT);
    check_all("parity good");
    send(8'h07, 1'b1, 1'b0);
    idle(BIT);
    check_all("parity bad");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
